// File: rtl/result_uart_tx.sv
// Serialises a snapshot of three result bytes as one 8N1 UART packet: HEADER, v1, v2, v3.
// Define RESULT_TX_CHECKSUM_EN to append CHK = HEADER ^ v1 ^ v2 ^ v3 as a fifth byte.
module result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  HEADER       = 8'hA5,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic [7:0] v1,
  input  logic [7:0] v2,
  input  logic [7:0] v3,
  output logic       tx,
  output logic       busy,
  output logic       done
);

`ifdef RESULT_TX_CHECKSUM_EN
  localparam int unsigned N_BYTES = 5;
`else
  localparam int unsigned N_BYTES = 4;
`endif

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BYTE_LAST = 3'(N_BYTES - 1);
  localparam logic        STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t      state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [2:0]  byte_idx;
  logic        stop_cnt;
  logic [7:0]  snap_v1;
  logic [7:0]  snap_v2;
  logic [7:0]  snap_v3;
  logic [7:0]  shift;
  logic [7:0]  next_byte;
  logic        bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // Byte that follows the one currently indexed by byte_idx (index 0 is HEADER).
  always_comb begin
    // NOTE: default assignment first so every path drives next_byte and no latch is inferred.
    next_byte = 8'h00;
    case (byte_idx)
      3'd0:    next_byte = snap_v1;
      3'd1:    next_byte = snap_v2;
      3'd2:    next_byte = snap_v3;
`ifdef RESULT_TX_CHECKSUM_EN
      3'd3:    next_byte = HEADER ^ snap_v1 ^ snap_v2 ^ snap_v3;
`endif
      default: next_byte = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      stop_cnt <= 1'b0;
      snap_v1  <= '0;
      snap_v2  <= '0;
      snap_v3  <= '0;
      shift    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (start) begin
            snap_v1  <= v1;
            snap_v2  <= v2;
            snap_v3  <= v3;
            shift    <= HEADER;
            byte_idx <= '0;
            baud_cnt <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              stop_cnt <= 1'b0;
              tx       <= 1'b1;
              state    <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (stop_cnt == STOP_LAST) begin
              if (byte_idx == BYTE_LAST) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end else begin
                byte_idx <= byte_idx + 3'd1;
                shift    <= next_byte;
                tx       <= 1'b0;
                state    <= S_START;
              end
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        // Start is deliberately not sampled here; a held start is taken in the next IDLE cycle.
        S_DONE: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: directed steps, a tx-line byte decoder and an expected-byte queue.
module tb_result_uart_tx;

  localparam int CPB = 4;
`ifdef RESULT_TX_CHECKSUM_EN
  localparam int N_BYTES = 5;
`else
  localparam int N_BYTES = 4;
`endif
  localparam int PKT_A = N_BYTES * 10 * CPB;
  localparam int PKT_B = N_BYTES * 11 * CPB;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [7:0] v1 = 8'h00;
  logic [7:0] v2 = 8'h00;
  logic [7:0] v3 = 8'h00;
  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int dt = 0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  result_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .nrst(nrst), .start(start_a), .v1(v1), .v2(v2), .v3(v3),
    .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  result_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .nrst(nrst), .start(start_b), .v1(v1), .v2(v2), .v3(v3),
    .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_packet(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    exp_q.push_back(8'hA5);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
`ifdef RESULT_TX_CHECKSUM_EN
    exp_q.push_back(8'hA5 ^ b1 ^ b2 ^ b3);
`endif
  endtask

  // Waits (bounded) for done of DUT a (sel=0) or b (sel=1); returns cycles since t0.
  task automatic wait_done(input logic sel, output int cycles);
    logic seen;
    seen = 1'b0;
    cycles = -1;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if ((sel ? done_b : done_a) === 1'b1) begin
        seen = 1'b1;
        cycles = cyc - t0;
      end
    end
    if (!seen) check("done_timeout", 32'(sel ? done_b : done_a), 32'd1);
  endtask

  // Decoder on the selected tx line, sampling mid-bit on negedges.
  logic       mon_sel = 1'b0;
  logic       tx_mon;
  int         mon_sb;
  logic       in_frame = 1'b0;
  int         mcnt = 0;
  logic [7:0] rx = 8'h00;

  always_comb begin
    tx_mon = mon_sel ? tx_b : tx_a;
    mon_sb = mon_sel ? 2 : 1;
  end

  always @(negedge clk) begin
    if (nrst !== 1'b1) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (tx_mon === 1'b0) begin
        in_frame = 1'b1;
        mcnt = 0;
      end
    end else begin
      mcnt++;
      if (mcnt == 2) begin
        check("start_bit", 32'(tx_mon), 32'd0);
      end else if (mcnt >= 6 && mcnt <= 34 && (mcnt - 2) % 4 == 0) begin
        rx[(mcnt - 6) / 4] = tx_mon;
      end else if (mcnt >= 38 && (mcnt - 2) % 4 == 0) begin
        check("stop_bit", 32'(tx_mon), 32'd1);
        if (mcnt == 4 * (9 + mon_sb) - 2) begin
          if (exp_q.size() == 0) check("unexpected_byte", 32'(rx), 32'h100);
          else check("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
          in_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset held three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", 32'(tx_a), 32'd1);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_tx_b", 32'(tx_b), 32'd1);
    end
    nrst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_tx", 32'(tx_a), 32'd1);
      check("post_rst_busy", 32'(busy_a), 32'd0);
    end

    // 2/3: single packet, latency and length.
    v1 = 8'h12; v2 = 8'h34; v3 = 8'h56;
    push_packet(8'h12, 8'h34, 8'h56);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("latency_tx", 32'(tx_a), 32'd0);
    check("latency_busy", 32'(busy_a), 32'd1);
    t0 = cyc;
    wait_done(1'b0, dt);
    check("pkt_len", 32'(dt), 32'(PKT_A));
    check("busy_at_done", 32'(busy_a), 32'd0);
    check("tx_at_done", 32'(tx_a), 32'd1);
    @(negedge clk);
    check("done_pulse", 32'(done_a), 32'd0);
    check("q_empty_1", 32'(exp_q.size()), 32'd0);

    // 4: start and v1 change mid-packet are ignored.
    repeat (3) @(negedge clk);
    push_packet(8'h12, 8'h34, 8'h56);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    t0 = cyc;
    repeat (50) @(negedge clk);
    start_a = 1'b1;
    v1 = 8'hFF;
    @(negedge clk);
    start_a = 1'b0;
    check("busy_mid", 32'(busy_a), 32'd1);
    wait_done(1'b0, dt);
    check("pkt_len_mid", 32'(dt), 32'(PKT_A));
    repeat (10) @(negedge clk);
    check("no_requeue_tx", 32'(tx_a), 32'd1);
    check("no_requeue_busy", 32'(busy_a), 32'd0);
    check("q_empty_2", 32'(exp_q.size()), 32'd0);

    // 5: reset during v2 data bits aborts, then a fresh packet goes out whole.
    v1 = 8'hAB; v2 = 8'hCD; v3 = 8'hEF;
    push_packet(8'hAB, 8'hCD, 8'hEF);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    t0 = cyc;
    repeat (95) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    check("abort_tx", 32'(tx_a), 32'd1);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_v2_pending", 32'(exp_q.size()), 32'(N_BYTES - 2));
    nrst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    v1 = 8'h01; v2 = 8'h80; v3 = 8'hFF;
    push_packet(8'h01, 8'h80, 8'hFF);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("restart_tx", 32'(tx_a), 32'd0);
    t0 = cyc;
    wait_done(1'b0, dt);
    check("pkt_len_restart", 32'(dt), 32'(PKT_A));
    repeat (3) @(negedge clk);
    check("q_empty_3", 32'(exp_q.size()), 32'd0);

    // 6: two stop bits, start held high -> back-to-back packets.
    mon_sel = 1'b1;
    v1 = 8'h5A; v2 = 8'hC3; v3 = 8'h0F;
    push_packet(8'h5A, 8'hC3, 8'h0F);
    push_packet(8'h5A, 8'hC3, 8'h0F);
    start_b = 1'b1;
    @(negedge clk);
    check("b_latency_tx", 32'(tx_b), 32'd0);
    t0 = cyc;
    wait_done(1'b1, dt);
    check("b_pkt_len_1", 32'(dt), 32'(PKT_B));
    check("b_busy_at_done", 32'(busy_b), 32'd0);
    @(negedge clk);
    check("b_idle_gap_tx", 32'(tx_b), 32'd1);
    check("b_idle_gap_busy", 32'(busy_b), 32'd0);
    check("b_idle_gap_done", 32'(done_b), 32'd0);
    @(negedge clk);
    check("b_second_start_tx", 32'(tx_b), 32'd0);
    check("b_second_busy", 32'(busy_b), 32'd1);
    start_b = 1'b0;
    t0 = cyc;
    wait_done(1'b1, dt);
    check("b_pkt_len_2", 32'(dt), 32'(PKT_B));
    repeat (8) @(negedge clk);
    check("b_no_third_tx", 32'(tx_b), 32'd1);
    check("b_no_third_busy", 32'(busy_b), 32'd0);
    check("q_empty_4", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
